// File: rtl/soc_system_pio_arb_pkg.sv
// Shared types and sizing helpers for the PIO slave-port arbiter.
package soc_system_pio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2,
        RESP    = 2'd3
    } state_t;

    // Wide enough to count down READ_LATENCY-1 for latencies up to 4.
    localparam int LAT_CNT_W = 3;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/soc_system_pio_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after the pointer, wrapping.
module soc_system_pio_rr_arbiter
    import soc_system_pio_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any
);

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        // Upper segment [ptr, NUM_REQ) first, then wrap to [0, ptr).
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && (i >= int'(i_ptr)) && i_req[i]) begin
                o_any       = 1'b1;
                o_grant[i]  = 1'b1;
                o_grant_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && (i < int'(i_ptr)) && i_req[i]) begin
                o_any       = 1'b1;
                o_grant[i]  = 1'b1;
                o_grant_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/soc_system_pio_arbiter.sv
// Serialises NUM_REQ valid/ready requesters onto one PIO Avalon-MM slave port,
// one transaction at a time, round-robin, with fixed read latency.
module soc_system_pio_arbiter
    import soc_system_pio_arb_pkg::*;
#(
    parameter int NUM_REQ      = 2,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 2,
    parameter int READ_LATENCY = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_readdata,
    output logic [ADDR_W-1:0]         pio_address,
    output logic                      pio_chipselect,
    output logic                      pio_write_n,
    output logic [DATA_W-1:0]         pio_writedata,
    input  logic [DATA_W-1:0]         pio_readdata
);

    localparam int IDX_W = clog2(NUM_REQ);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [IDX_W-1:0]       r_ptr;
    logic [IDX_W-1:0]       r_grant_idx;
    logic                   r_write;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic [DATA_W-1:0]      r_rdata;
    logic [LAT_CNT_W-1:0]   r_lat_cnt;
    logic                   r_cs;
    logic                   r_write_n;
    logic [NUM_REQ-1:0]     r_rsp_valid;

    logic [NUM_REQ-1:0]     w_grant;
    logic [IDX_W-1:0]       w_grant_idx;
    logic                   w_any;
    logic                   w_accept;
    logic                   w_lat_done;
    logic                   w_sel_write;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [DATA_W-1:0]      w_sel_wdata;

    soc_system_pio_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req       (req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    always_comb begin
        w_accept     = (r_state == IDLE) && w_any;
        w_lat_done   = (r_lat_cnt == '0);
        w_sel_write  = req_write[w_grant_idx];
        w_sel_addr   = req_address[int'(w_grant_idx)*ADDR_W +: ADDR_W];
        w_sel_wdata  = req_writedata[int'(w_grant_idx)*DATA_W +: DATA_W];
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = ISSUE;
            ISSUE:   w_next_state = r_write ? RESP : RD_WAIT;
            RD_WAIT: if (w_lat_done) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_grant_idx <= '0;
            r_write     <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_lat_cnt   <= '0;
            r_cs        <= 1'b0;
            r_write_n   <= 1'b1;
            r_rsp_valid <= '0;
        end else begin
            r_state <= w_next_state;
            // Strobes are registered so the slave sees clean per-cycle levels.
            r_cs        <= (w_next_state == ISSUE);
            r_write_n   <= !(w_accept && w_sel_write);
            r_rsp_valid <= '0;
            if (w_next_state == RESP) begin
                r_rsp_valid[r_grant_idx] <= 1'b1;
            end

            if (w_accept) begin
                r_write     <= w_sel_write;
                r_addr      <= w_sel_addr;
                r_wdata     <= w_sel_wdata;
                r_grant_idx <= w_grant_idx;
                if (w_grant_idx == IDX_W'(NUM_REQ - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= w_grant_idx + 1'b1;
                end
            end

            if ((r_state == ISSUE) && !r_write) begin
                r_lat_cnt <= LAT_CNT_W'(READ_LATENCY - 1);
            end else if ((r_state == RD_WAIT) && !w_lat_done) begin
                r_lat_cnt <= r_lat_cnt - 1'b1;
            end

            // rsp_readdata only changes when a read completes.
            if ((r_state == RD_WAIT) && w_lat_done) begin
                r_rdata <= pio_readdata;
            end
        end
    end

    assign req_ready      = (reset_n && (r_state == IDLE)) ? w_grant : '0;
    assign rsp_valid      = r_rsp_valid;
    assign rsp_readdata   = r_rdata;
    assign pio_address    = r_addr;
    assign pio_chipselect = r_cs;
    assign pio_write_n    = r_write_n;
    assign pio_writedata  = r_wdata;

endmodule

// File: tb/tb_soc_system_pio_arbiter.sv
// Directed bench for the PIO arbiter: table-driven single transactions plus
// round-robin, reset-abort, dropped-valid and READ_LATENCY=3 sequences.
module tb_soc_system_pio_arbiter;

    localparam int N  = 2;
    localparam int DW = 32;
    localparam int AW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
    logic [N*AW-1:0] req_address;
    logic [N*DW-1:0] req_writedata;
    logic [DW-1:0]   rsp_readdata, pio_writedata, pio_readdata;
    logic [AW-1:0]   pio_address;
    logic            pio_chipselect, pio_write_n;

    logic [N-1:0]    b_req_valid, b_req_write, b_req_ready, b_rsp_valid;
    logic [N*AW-1:0] b_req_address;
    logic [N*DW-1:0] b_req_writedata;
    logic [DW-1:0]   b_rsp_readdata, b_pio_writedata, b_pio_readdata;
    logic [AW-1:0]   b_pio_address;
    logic            b_pio_chipselect, b_pio_write_n;

    soc_system_pio_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_write(req_write), .req_address(req_address),
        .req_writedata(req_writedata), .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_readdata(rsp_readdata), .pio_address(pio_address),
        .pio_chipselect(pio_chipselect), .pio_write_n(pio_write_n),
        .pio_writedata(pio_writedata), .pio_readdata(pio_readdata)
    );

    soc_system_pio_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(b_req_valid), .req_write(b_req_write), .req_address(b_req_address),
        .req_writedata(b_req_writedata), .req_ready(b_req_ready), .rsp_valid(b_rsp_valid),
        .rsp_readdata(b_rsp_readdata), .pio_address(b_pio_address),
        .pio_chipselect(b_pio_chipselect), .pio_write_n(b_pio_write_n),
        .pio_writedata(b_pio_writedata), .pio_readdata(b_pio_readdata)
    );

    // PIO slave models: address 0 is the data register, others read as zero.
    logic [DW-1:0] in_port, out_port, rd1;
    logic [DW-1:0] b_in_port, b_out_port, b_d1, b_d2, b_d3;

    always @(posedge clk) begin
        if (pio_chipselect && !pio_write_n && pio_address == 2'd0) out_port <= pio_writedata;
        rd1 <= (pio_chipselect && pio_write_n && pio_address == 2'd0) ? in_port : '0;
        if (b_pio_chipselect && !b_pio_write_n && b_pio_address == 2'd0) b_out_port <= b_pio_writedata;
        b_d1 <= (b_pio_chipselect && b_pio_write_n && b_pio_address == 2'd0) ? b_in_port : '0;
        b_d2 <= b_d1;
        b_d3 <= b_d2;
    end
    assign pio_readdata   = rd1;
    assign b_pio_readdata = b_d3;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        wr;
        int          id;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] inp;
        logic [31:0] exp_rdata;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[7];

    // Starts from IDLE with no other requester valid; checks every cycle to the response.
    task automatic run_vec(input vec_t v);
        int           rsp_at;
        logic [N-1:0] oh;
        rsp_at = v.wr ? 2 : 3;
        oh = '0;
        oh[v.id] = 1'b1;
        step();
        in_port = v.inp;
        req_valid = '0;
        req_valid[v.id] = 1'b1;
        req_write[v.id] = v.wr;
        req_address[v.id*AW +: AW] = v.addr;
        req_writedata[v.id*DW +: DW] = v.wdata;
        #1;
        check("ready_T0", req_ready, oh);
        step();
        req_valid = '0;
        req_write = ~req_write;
        req_address = ~req_address;
        req_writedata = ~req_writedata;
        #1;
        check("cs_T1", pio_chipselect, 1'b1);
        check("write_n_T1", pio_write_n, !v.wr);
        check("addr_T1", pio_address, v.addr);
        if (v.wr) check("wdata_T1", pio_writedata, v.wdata);
        check("ready_busy", req_ready, '0);
        for (int t = 2; t <= rsp_at; t++) begin
            step();
            #1;
            check("cs_after", pio_chipselect, 1'b0);
            check("rsp_valid", rsp_valid, (t == rsp_at) ? oh : '0);
        end
        check("rsp_readdata", rsp_readdata, v.exp_rdata);
        check("out_port", out_port, v.exp_out);
        step();
        #1;
        check("rsp_pulse_end", rsp_valid, '0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int sent[2];
        int rsps[2];
        int multi, cs_cnt, r0, r1, rdy, rsp_t;
        int order[$];
        logic [31:0] cap;

        reset_n = 1'b0;
        req_valid = '1; req_write = '0; req_address = '0; req_writedata = '0;
        b_req_valid = '0; b_req_write = '0; b_req_address = '0; b_req_writedata = '0;
        in_port = '0; b_in_port = '0;
        step();
        step();
        #1;
        check("rst_ready", req_ready, '0);
        check("rst_rsp_valid", rsp_valid, '0);
        check("rst_rdata", rsp_readdata, '0);
        check("rst_cs", pio_chipselect, 1'b0);
        check("rst_write_n", pio_write_n, 1'b1);
        check("rst_addr", pio_address, '0);
        check("rst_wdata", pio_writedata, '0);
        req_valid = '0;
        step();
        reset_n = 1'b1;

        vecs[0] = '{1'b1, 0, 2'd0, 32'hDEADBEEF, 32'h0,        32'h0,        32'hDEADBEEF};
        vecs[1] = '{1'b0, 1, 2'd0, 32'h0,        32'h12345678, 32'h12345678, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 1, 2'd1, 32'h0,        32'h12345678, 32'h0,        32'hDEADBEEF};
        vecs[3] = '{1'b1, 1, 2'd0, 32'hCAFEF00D, 32'h0,        32'h0,        32'hCAFEF00D};
        vecs[4] = '{1'b1, 0, 2'd2, 32'h11111111, 32'h0,        32'h0,        32'hCAFEF00D};
        vecs[5] = '{1'b0, 0, 2'd0, 32'h0,        32'h5A5A0001, 32'h5A5A0001, 32'hCAFEF00D};
        vecs[6] = '{1'b1, 1, 2'd3, 32'h0BADC0DE, 32'h0,        32'h5A5A0001, 32'hCAFEF00D};
        for (int k = 0; k < 7; k++) run_vec(vecs[k]);

        // Both requesters streaming writes: grants must alternate.
        sent = '{0, 0};
        rsps = '{0, 0};
        multi = 0;
        for (int c = 0; c < 80; c++) begin
            if (sent[0] == 4 && sent[1] == 4 && rsps[0] == 4 && rsps[1] == 4) break;
            step();
            for (int i = 0; i < N; i++) begin
                req_valid[i] = (sent[i] < 4);
                req_write[i] = 1'b1;
                req_address[i*AW +: AW] = 2'd0;
                req_writedata[i*DW +: DW] = 32'h100 + c;
            end
            #1;
            if ($countones(req_ready) > 1) multi++;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    order.push_back(i);
                    sent[i]++;
                end
                if (rsp_valid[i]) rsps[i]++;
            end
        end
        req_valid = '0;
        check("rr_count", order.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < order.size()) check("rr_order", order[k], k % 2);
        end
        check("rr_onehot", multi, 0);
        check("rr_rsp0", rsps[0], 4);
        check("rr_rsp1", rsps[1], 4);

        // Reset while a read waits on the slave: abandoned, pointer back to 0.
        step();
        req_valid = 2'b01; req_write = 2'b00; req_address = 4'b0011;
        #1;
        check("abort_ready", req_ready, 2'b01);
        step();
        req_valid = '0;
        step();
        reset_n = 1'b0;
        step();
        req_valid = 2'b11;
        #1;
        check("abort_rsp_valid", rsp_valid, '0);
        check("abort_ready_rst", req_ready, '0);
        check("abort_rdata", rsp_readdata, '0);
        check("abort_cs", pio_chipselect, 1'b0);
        check("abort_write_n", pio_write_n, 1'b1);
        check("abort_addr", pio_address, '0);
        check("abort_wdata", pio_writedata, '0);
        step();
        reset_n = 1'b1;
        #1;
        check("abort_ptr0", req_ready, 2'b01);
        #1;
        req_valid = '0;
        r0 = 0; cs_cnt = 0;
        for (int t = 0; t < 4; t++) begin
            step();
            #1;
            r0 += $countones(rsp_valid);
            cs_cnt += int'(pio_chipselect);
        end
        check("abort_no_rsp", r0, 0);
        check("abort_no_cs", cs_cnt, 0);

        // req0 pulses valid while busy, then drops it: nothing happens for req0.
        step();
        req_valid = 2'b10; req_write = 2'b10; req_address = '0;
        req_writedata[DW +: DW] = 32'h00000077;
        #1;
        check("drop_ready1", req_ready, 2'b10);
        cs_cnt = 0; r0 = 0; r1 = 0; rdy = 0;
        for (int t = 1; t <= 9; t++) begin
            step();
            req_valid = (t == 1) ? 2'b01 : 2'b00;
            #1;
            cs_cnt += int'(pio_chipselect);
            r0 += int'(rsp_valid[0]);
            r1 += int'(rsp_valid[1]);
            if (req_ready != '0) rdy++;
        end
        check("drop_cs", cs_cnt, 1);
        check("drop_rsp0", r0, 0);
        check("drop_rsp1", r1, 1);
        check("drop_ready", rdy, 0);
        check("drop_out", out_port, 32'h00000077);

        // READ_LATENCY=3 instance.
        step();
        b_in_port = 32'hA5A5A5A5;
        b_req_valid = 2'b01; b_req_write = 2'b00; b_req_address = '0;
        #1;
        check("rl3_ready", b_req_ready, 2'b01);
        rsp_t = -1; cs_cnt = 0; r0 = 0; cap = '0;
        for (int t = 1; t <= 8; t++) begin
            step();
            b_req_valid = '0;
            if (t == 2) b_in_port = 32'h0;
            #1;
            cs_cnt += int'(b_pio_chipselect);
            if (b_rsp_valid[0]) begin
                r0++;
                rsp_t = t;
                cap = b_rsp_readdata;
            end
        end
        check("rl3_rsp_cycle", rsp_t, 5);
        check("rl3_rsp_count", r0, 1);
        check("rl3_rdata", cap, 32'hA5A5A5A5);
        check("rl3_cs", cs_cnt, 1);
        step();
        b_req_valid = 2'b10; b_req_write = 2'b10;
        b_req_writedata[DW +: DW] = 32'h00C0FFEE;
        #1;
        check("rl3_wr_ready", b_req_ready, 2'b10);
        r1 = 0;
        for (int t = 1; t <= 4; t++) begin
            step();
            b_req_valid = '0;
            #1;
            r1 += int'(b_rsp_valid[1]);
        end
        check("rl3_wr_rsp", r1, 1);
        check("rl3_rdata_kept", b_rsp_readdata, 32'hA5A5A5A5);
        check("rl3_out", b_out_port, 32'h00C0FFEE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
